lz77_enc_ctrl: RTL and testbench
================================

LZ77_ENC_CTRL -- requirements
Module: lz77_enc_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, symbol width.
REQ-002 SHALL have parameter DICT_DEPTH_LOG, default 4, match-position width.
REQ-003 SHALL have parameter CNT_WIDTH, default 3, match-length width.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4 (power of 2, >=4), token FIFO entries.
REQ-005 SHALL have ports, in order:
- clk  in  1  clock; one clock domain, all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- s_valid  in  1  input byte valid.
- s_data  in  DATA_WIDTH  input byte.
- s_last  in  1  last byte of block.
- s_ready  out  1  byte accepted when s_valid & s_ready.
- enc_rst_n  out  1  encoder reset, active-low; clears dictionary.
- enc_data_valid  out  1  encoder shift/search enable.
- enc_data  out  DATA_WIDTH  encoder input byte.
- enc_match_position  in  DICT_DEPTH_LOG  encoder match position.
- enc_match_length  in  CNT_WIDTH  encoder match length.
- enc_next_symbol  in  DATA_WIDTH  encoder next symbol.
- enc_output_enable  in  1  encoder token valid (combinational from enc_data_valid).
- m_valid  out  1  token valid.
- m_position  out  DICT_DEPTH_LOG  token position.
- m_length  out  CNT_WIDTH  token length.
- m_symbol  out  DATA_WIDTH  token symbol.
- m_last  out  1  final token of block.
- m_ready  in  1  token consumed when m_valid & m_ready.
- busy  out  1  state != IDLE.
- blk_count  out  16  completed blocks, wraps 0xFFFF->0.

Function
REQ-006 SHALL implement FSM states IDLE, CLR, RUN, DRAIN.
REQ-007 SHALL move IDLE->CLR when s_valid=1; IDLE holds s_ready=0 (byte not consumed).
REQ-008 SHALL stay in CLR exactly one cycle with enc_rst_n=0, then enter RUN.
REQ-009 SHALL drive enc_rst_n = 0 whenever rst=1 or state=CLR, else 1 (combinational).
REQ-010 SHALL drive s_ready = 1 only in RUN with FIFO count <= FIFO_DEPTH-2.
REQ-011 SHALL drive enc_data_valid = s_valid & s_ready and enc_data = s_data, combinationally, zero latency.
REQ-012 SHALL push a token when enc_data_valid & (enc_output_enable | s_last): fields enc_match_position, enc_match_length, enc_next_symbol, and last = s_last.
REQ-013 SHALL force a push on the last byte even if enc_output_enable=0, so a pending match is never lost.
REQ-014 SHALL move RUN->DRAIN in the cycle the s_last byte is accepted.
REQ-015 SHALL move DRAIN->IDLE when FIFO is empty, incrementing blk_count in that same transition.
REQ-016 SHALL give m_valid = (count != 0); m_* outputs SHALL show the FIFO head entry, first-word-fall-through.
REQ-017 SHALL pop on m_valid & m_ready; simultaneous push and pop SHALL leave count unchanged and preserve order.
REQ-018 SHALL never overflow: REQ-010 guarantees space; push when full SHALL NOT occur, and an assertion flags it.
REQ-019 SHALL ignore enc_output_enable when enc_data_valid=0 (encoder max-length artefact).
REQ-020 SHALL hold m_* stable while m_valid=1 and m_ready=0.

Reset
REQ-021 SHALL, while rst=1, force state IDLE, FIFO count 0, pointers 0, blk_count 0, m_valid 0, s_ready 0, enc_data_valid 0, busy 0, enc_rst_n 0.
REQ-022 SHALL, on rst mid-block, discard all queued tokens; the next block starts with CLR.
REQ-023 SHALL release from reset synchronously to clk: first state update on the first posedge after rst falls.

Verification
REQ-024 Block "ABC" (s_last on C), m_ready=1, encoder emits 3 tokens -> 3 tokens in order, m_last only on C, blk_count=1, enc_rst_n low exactly 1 cycle before first accept.
REQ-025 Block "AAAA": encoder emits for bytes 1-3 only -> 4th byte force-pushes with m_length = encoder length, m_last=1.
REQ-026 m_ready=0, stream 8 tokenising bytes -> s_ready drops after count=3 (FIFO_DEPTH=4); no token lost or reordered after m_ready=1.
REQ-027 Simultaneous push/pop at count=2 -> count stays 2, head advances by one.
REQ-028 rst asserted in RUN with count=2 -> m_valid=0 and enc_rst_n=0 immediately; next block shows CLR then RUN, blk_count unchanged.
REQ-029 Two back-to-back blocks -> each preceded by one CLR cycle, blk_count 0->1->2, busy low at least one cycle between blocks.

Source files
------------

// File: rtl/lz77_enc_ctrl.sv
// LZ77 encoder front-end: gates input bytes into the encoder, clears its dictionary
// at each block start, and queues emitted tokens in a first-word-fall-through FIFO.
module lz77_enc_ctrl #(
  parameter int DATA_WIDTH     = 8,
  parameter int DICT_DEPTH_LOG = 4,
  parameter int CNT_WIDTH      = 3,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      s_valid,
  input  logic [DATA_WIDTH-1:0]     s_data,
  input  logic                      s_last,
  output logic                      s_ready,
  output logic                      enc_rst_n,
  output logic                      enc_data_valid,
  output logic [DATA_WIDTH-1:0]     enc_data,
  input  logic [DICT_DEPTH_LOG-1:0] enc_match_position,
  input  logic [CNT_WIDTH-1:0]      enc_match_length,
  input  logic [DATA_WIDTH-1:0]     enc_next_symbol,
  input  logic                      enc_output_enable,
  output logic                      m_valid,
  output logic [DICT_DEPTH_LOG-1:0] m_position,
  output logic [CNT_WIDTH-1:0]      m_length,
  output logic [DATA_WIDTH-1:0]     m_symbol,
  output logic                      m_last,
  input  logic                      m_ready,
  output logic                      busy,
  output logic [15:0]               blk_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int TOK_W = DICT_DEPTH_LOG + CNT_WIDTH + DATA_WIDTH + 1;

  typedef enum logic [1:0] {IDLE, CLR, RUN, DRAIN} state_t;

  state_t             state, state_nxt;
  logic [PTR_W:0]     count;
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [TOK_W-1:0]   mem [FIFO_DEPTH];
  logic               accept, push, pop, fifo_empty, blk_done;

  assign fifo_empty = (count == '0);
  assign accept     = s_valid & s_ready;
  assign push       = accept & (enc_output_enable | s_last);
  assign pop        = ~fifo_empty & m_ready;
  assign blk_done   = (state == DRAIN) & fifo_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (s_valid) state_nxt = CLR;
      CLR:     state_nxt = RUN;
      RUN:     if (accept && s_last) state_nxt = DRAIN;
      DRAIN:   if (fifo_empty) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Holding one slot in reserve keeps a push from ever meeting a full FIFO.
  always_comb begin
    s_ready   = (state == RUN) && (count <= (PTR_W+1)'(FIFO_DEPTH - 2));
    busy      = (state != IDLE);
    enc_rst_n = ~(rst | (state == CLR));
  end

  assign enc_data_valid = accept;
  assign enc_data       = s_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {enc_match_position, enc_match_length, enc_next_symbol, s_last};
  end

  assign m_valid = ~fifo_empty;
  assign {m_position, m_length, m_symbol, m_last} = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           blk_count <= '0;
    else if (blk_done) blk_count <= blk_count + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst) assert (!(push && count == (PTR_W+1)'(FIFO_DEPTH)));
  end

endmodule

// File: tb/tb_lz77_enc_ctrl.sv
// Randomised bench for lz77_enc_ctrl: a queue-based token model is compared with the
// DUT on every falling edge, with directed blocks pinning the model to literal values.
module tb_lz77_enc_ctrl;
  localparam int DW = 8, DL = 4, CW = 3, FD = 4;
  localparam int P_IDLE = 0, P_CLR = 1, P_RUN = 2, P_DRAIN = 3;

  logic clk = 1'b0;
  logic rst;
  logic s_valid, s_last, s_ready;
  logic [DW-1:0] s_data;
  logic enc_rst_n, enc_data_valid, enc_output_enable;
  logic [DW-1:0] enc_data, enc_next_symbol, m_symbol;
  logic [DL-1:0] enc_match_position, m_position;
  logic [CW-1:0] enc_match_length, m_length;
  logic m_valid, m_last, m_ready, busy;
  logic [15:0] blk_count;

  logic oe_bit;
  logic [DW-1:0] sym_mask;
  int mr_mode;

  // encoder stub: token valid is combinational from enc_data_valid
  assign enc_output_enable = enc_data_valid & oe_bit;
  assign enc_next_symbol   = s_data ^ sym_mask;

  lz77_enc_ctrl #(.DATA_WIDTH(DW), .DICT_DEPTH_LOG(DL), .CNT_WIDTH(CW), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_last(s_last),
    .s_ready(s_ready), .enc_rst_n(enc_rst_n), .enc_data_valid(enc_data_valid),
    .enc_data(enc_data), .enc_match_position(enc_match_position),
    .enc_match_length(enc_match_length), .enc_next_symbol(enc_next_symbol),
    .enc_output_enable(enc_output_enable), .m_valid(m_valid), .m_position(m_position),
    .m_length(m_length), .m_symbol(m_symbol), .m_last(m_last), .m_ready(m_ready),
    .busy(busy), .blk_count(blk_count)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [DL-1:0] pos;
    logic [CW-1:0] len;
    logic [DW-1:0] sym;
    logic          last;
  } tok_t;

  tok_t q[$];
  tok_t log_q[$];
  int ph = P_IDLE;
  logic [15:0] blk = '0;
  bit m_rdy, m_acc, m_empty;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ph  = P_IDLE;
      q.delete();
      blk = '0;
    end else begin
      m_rdy   = (ph == P_RUN) && (q.size() <= FD - 2);
      m_acc   = s_valid && m_rdy;
      m_empty = (q.size() == 0);
      if (!m_empty && m_ready) log_q.push_back(q.pop_front());
      if (m_acc && (oe_bit || s_last))
        q.push_back(tok_t'{enc_match_position, enc_match_length, s_data ^ sym_mask, s_last});
      case (ph)
        P_IDLE:  if (s_valid) ph = P_CLR;
        P_CLR:   ph = P_RUN;
        P_RUN:   if (m_acc && s_last) ph = P_DRAIN;
        default: if (m_empty) begin ph = P_IDLE; blk = blk + 16'd1; end
      endcase
    end
  end

  // ---------------- compare process ----------------
  int clr_cnt = 0;
  bit e_rdy;
  always @(negedge clk) begin
    e_rdy = (ph == P_RUN) && (q.size() <= FD - 2);
    chk("s_ready", s_ready, e_rdy);
    chk("busy", busy, ph != P_IDLE);
    chk("enc_rst_n", enc_rst_n, !(rst || ph == P_CLR));
    chk("enc_data_valid", enc_data_valid, s_valid && e_rdy);
    if (s_valid && e_rdy) chk("enc_data", enc_data, s_data);
    chk("m_valid", m_valid, q.size() != 0);
    if (q.size() != 0) begin
      chk("m_position", m_position, q[0].pos);
      chk("m_length", m_length, q[0].len);
      chk("m_symbol", m_symbol, q[0].sym);
      chk("m_last", m_last, q[0].last);
    end
    chk("blk_count", blk_count, blk);
    if (!enc_rst_n && !rst) clr_cnt++;
  end

  // encoder fields and sink readiness change every cycle
  initial begin
    m_ready = 1'b1;
    enc_match_position = '0;
    enc_match_length = '0;
    forever begin
      @(posedge clk); #1;
      enc_match_position = DL'($urandom);
      enc_match_length   = CW'($urandom);
      if (mr_mode == 2) m_ready = 1'($urandom_range(0, 1));
      else              m_ready = (mr_mode == 1);
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic send_byte(input logic [DW-1:0] d, input logic last, input logic oe);
    bit rdy, done;
    done = 0;
    s_valid = 1'b1; s_data = d; s_last = last; oe_bit = oe;
    for (int n = 0; n < 200 && !done; n++) begin
      #3 rdy = s_ready;
      cyc();
      done = rdy;
    end
    if (!done) begin
      n_fail++;
      $display("FAIL send_timeout: byte %0h not accepted, required within 200 cycles", d);
    end
    s_valid = 1'b0; s_last = 1'b0; oe_bit = 1'b0;
  endtask

  task automatic wait_idle();
    bit done;
    done = 0;
    for (int n = 0; n < 300 && !done; n++) begin
      if (!busy) done = 1;
      else cyc();
    end
    if (!done) begin
      n_fail++;
      $display("FAIL idle_timeout: busy=%0b, required 0 within 300 cycles", busy);
    end
  endtask

  initial begin
    rst = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = '0;
    oe_bit = 1'b0; sym_mask = '0; mr_mode = 1;
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_enc_rst_n", enc_rst_n, 0);
    chk("rst_s_ready", s_ready, 0);
    repeat (2) cyc();
    rst = 1'b0;
    cyc();
    chk("rst_blk_count", blk_count, 16'd0);

    // reset mid-block with two tokens queued
    mr_mode = 0; clr_cnt = 0;
    send_byte(8'h11, 1'b0, 1'b1);
    send_byte(8'h22, 1'b0, 1'b1);
    chk("mid_m_valid", m_valid, 1);
    chk("mid_clr_cnt", clr_cnt, 1);
    rst = 1'b1; #1;
    chk("mid_rst_m_valid", m_valid, 0);
    chk("mid_rst_enc_rst_n", enc_rst_n, 0);
    chk("mid_rst_busy", busy, 0);
    cyc(); rst = 1'b0; mr_mode = 1;
    cyc();

    // block "ABC"
    clr_cnt = 0; log_q.delete();
    send_byte(8'h41, 1'b0, 1'b1);
    send_byte(8'h42, 1'b0, 1'b1);
    send_byte(8'h43, 1'b1, 1'b1);
    wait_idle();
    chk("abc_ntok", log_q.size(), 3);
    if (log_q.size() == 3) begin
      chk("abc_sym0", log_q[0].sym, 8'h41);
      chk("abc_sym2", log_q[2].sym, 8'h43);
      chk("abc_last", {log_q[0].last, log_q[1].last, log_q[2].last}, 3'b001);
    end
    chk("abc_blk", blk_count, 16'd1);
    chk("abc_clr", clr_cnt, 1);

    // block "AAAA": the final byte pushes without enc_output_enable
    log_q.delete();
    send_byte(8'h41, 1'b0, 1'b1);
    send_byte(8'h41, 1'b0, 1'b1);
    send_byte(8'h41, 1'b0, 1'b1);
    send_byte(8'h41, 1'b1, 1'b0);
    wait_idle();
    chk("aaaa_ntok", log_q.size(), 4);
    if (log_q.size() == 4) chk("aaaa_last", log_q[3].last, 1);
    chk("aaaa_blk", blk_count, 16'd2);

    // back-pressure: eight tokenising bytes against a stalled sink
    log_q.delete(); mr_mode = 0;
    fork
      for (int i = 0; i < 8; i++) send_byte(DW'(8'h60 + i), i == 7, 1'b1);
      begin
        repeat (10) cyc();
        chk("bp_s_ready", s_ready, 0);
        chk("bp_model_cnt", q.size(), 3);
        chk("bp_m_symbol", m_symbol, 8'h60);
        mr_mode = 1;
      end
    join
    wait_idle();
    chk("bp_ntok", log_q.size(), 8);
    for (int i = 0; i < 8 && i < log_q.size(); i++) chk("bp_order", log_q[i].sym, 8'h60 + i);
    chk("bp_blk", blk_count, 16'd3);

    // two back-to-back blocks
    clr_cnt = 0;
    send_byte(8'h01, 1'b0, 1'b1);
    send_byte(8'h02, 1'b1, 1'b0);
    send_byte(8'h03, 1'b0, 1'b0);
    send_byte(8'h04, 1'b1, 1'b1);
    wait_idle();
    chk("b2b_clr", clr_cnt, 2);
    chk("b2b_blk", blk_count, 16'd5);

    // randomised blocks with sink stalls, input gaps and occasional resets
    mr_mode = 2;
    for (int b = 0; b < 40; b++) begin
      int len, rst_at;
      bit aborted;
      len = $urandom_range(1, 9);
      rst_at = ($urandom_range(0, 9) == 0) ? $urandom_range(0, len - 1) : -1;
      aborted = 0;
      sym_mask = DW'($urandom);
      for (int i = 0; i < len && !aborted; i++) begin
        if (i == rst_at) begin
          rst = 1'b1; cyc(); rst = 1'b0; cyc();
          aborted = 1;
        end else begin
          repeat ($urandom_range(0, 2)) cyc();
          send_byte(DW'($urandom), i == len - 1, 1'($urandom_range(0, 1)));
        end
      end
      if (!aborted) wait_idle();
    end
    mr_mode = 1;
    repeat (5) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, required completion by 2ms");
    $fatal(1, "timeout");
  end

endmodule
